gate_test_sequencer: RTL and testbench

GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

---
 rtl/gate_test_sequencer.sv | 142 ++++++++++++++
 tb/tb_gate_test_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gate_test_sequencer.sv
// Walks {a,b} through 00,01,10,11, lets the gate under test settle, then
// checks all seven gate outputs and records pass/fail details for the run.
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [6:0] i_y,
  output logic       o_a,
  output logic       o_b,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [2:0] o_err_cnt,
  output logic [6:0] o_fail_mask,
  output logic [1:0] o_first_fail,
  output logic       o_fail_valid
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ERR_W   = 3;
  localparam int unsigned GATES_W = 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e               state_q;
  logic [1:0]           idx_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 a_q, b_q;
  logic                 busy_q, done_q, pass_q, fail_valid_q;
  logic [ERR_W-1:0]     err_q;
  logic [GATES_W-1:0]   mask_q;
  logic [1:0]           first_q;

  logic [GATES_W-1:0]   exp_c;
  logic [GATES_W-1:0]   miss_c;
  logic                 fail_c;
  logic [ERR_W-1:0]     err_d;
  logic [1:0]           idx_d;

  // Reference truth table for the vector currently applied.
  always_comb begin
    exp_c  = '0;
    exp_c  = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q),
              a_q | b_q, a_q & b_q, ~a_q};
    miss_c = i_y ^ exp_c;
    fail_c = |miss_c;
    err_d  = (fail_c && (err_q != ERR_MAX)) ? err_q + ERR_W'(1) : err_q;
    idx_d  = idx_q + 2'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      mask_q       <= '0;
      first_q      <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q      <= SETTLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b1;
            pass_q       <= 1'b0;
            err_q        <= '0;
            mask_q       <= '0;
            first_q      <= '0;
            fail_valid_q <= 1'b0;
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CHECK: begin
          if (fail_c) begin
            err_q  <= err_d;
            mask_q <= mask_q | miss_c;
            if (!fail_valid_q) begin
              first_q      <= idx_q;
              fail_valid_q <= 1'b1;
            end
          end
          if (idx_q != 2'd3) begin
            idx_q   <= idx_d;
            a_q     <= idx_d[1];
            b_q     <= idx_d[0];
            cnt_q   <= '0;
            state_q <= SETTLE;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_a          = a_q;
  assign o_b          = b_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_pass       = pass_q;
  assign o_err_cnt    = err_q;
  assign o_fail_mask  = mask_q;
  assign o_first_fail = first_q;
  assign o_fail_valid = fail_valid_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Self-checking bench: a loopback gate model with injectable faults drives two
// sequencer instances (SETTLE_CYCLES=1 and 3); expected vectors go through a queue.
module tb_gate_test_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance with SETTLE_CYCLES=1
  logic       rst1, start1, a1, b1, busy1, done1, pass1, fv1;
  logic [6:0] y1, mask1;
  logic [2:0] err1;
  logic [1:0] first1;
  int         mode1 = 0;

  // Instance with SETTLE_CYCLES=3
  logic       rst3, start3, a3, b3, busy3, done3, pass3, fv3;
  logic [6:0] y3, mask3;
  logic [2:0] err3;
  logic [1:0] first3;

  function automatic logic [6:0] gate_f(input logic a, input logic b);
    gate_f = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
  endfunction

  // Gate under test: 0 = correct, 1 = XOR output stuck at 0, 2 = all outputs 0.
  function automatic logic [6:0] gut_f(input int mode, input logic a, input logic b);
    case (mode)
      1:       gut_f = gate_f(a, b) & 7'h5F;
      2:       gut_f = 7'h00;
      default: gut_f = gate_f(a, b);
    endcase
  endfunction

  assign y1 = gut_f(mode1, a1, b1);
  assign y3 = gut_f(0, a3, b3);

  gate_test_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_start(start1), .i_y(y1),
    .o_a(a1), .o_b(b1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
    .o_err_cnt(err1), .o_fail_mask(mask1), .o_first_fail(first1),
    .o_fail_valid(fv1)
  );

  gate_test_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rst(rst3), .i_start(start3), .i_y(y3),
    .o_a(a3), .o_b(b3), .o_busy(busy3), .o_done(done3), .o_pass(pass3),
    .o_err_cnt(err3), .o_fail_mask(mask3), .o_first_fail(first3),
    .o_fail_valid(fv3)
  );

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1; start1 = 1'b1; start3 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a1, b1, busy1, done1, pass1, err1, mask1, first1, fv1} !== 18'd0) begin
      errors++;
      $display("FAIL reset_dut1 got %b want all zero",
               {a1, b1, busy1, done1, pass1, err1, mask1, first1, fv1});
    end
    checks++;
    if ({a3, b3, busy3, done3, pass3, err3, mask3, first3, fv3} !== 18'd0) begin
      errors++;
      $display("FAIL reset_dut3 got %b want all zero",
               {a3, b3, busy3, done3, pass3, err3, mask3, first3, fv3});
    end
    @(posedge clk); #1;
    rst1 = 1'b0; rst3 = 1'b0; start1 = 1'b0; start3 = 1'b0;
  endtask

  // One SETTLE_CYCLES=1 run; poke pulses i_start during SETTLE and CHECK.
  task automatic run_sc1(input string name, input int mode, input bit poke);
    logic [1:0] q[$];
    logic [1:0] exp_ab;
    logic [6:0] m, e_mask;
    logic [2:0] e_err;
    logic [1:0] e_first;
    logic       e_fv;
    e_mask = '0; e_err = '0; e_first = '0; e_fv = 1'b0;
    for (int v = 0; v < 4; v++) begin
      logic [1:0] vv;
      vv = 2'(v);
      m = gut_f(mode, vv[1], vv[0]) ^ gate_f(vv[1], vv[0]);
      if (m != 7'd0) begin
        if (!e_fv) e_first = vv;
        e_fv = 1'b1;
        e_err = e_err + 3'd1;
        e_mask = e_mask | m;
      end
    end
    mode1 = mode;
    @(posedge clk); #1 start1 = 1'b1;
    for (int c = 1; c <= 9; c++) q.push_back((c > 8) ? 2'd3 : 2'((c - 1) / 2));
    @(posedge clk); #1 start1 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start1 = poke && (c == 1 || c == 2);
      exp_ab = q.pop_front();
      checks++;
      if ({a1, b1} !== exp_ab) begin
        errors++;
        $display("FAIL %s_vec cycle %0d got %b want %b", name, c, {a1, b1}, exp_ab);
      end
      checks++;
      if (done1 !== (c == 9) || busy1 !== 1'b1) begin
        errors++;
        $display("FAIL %s_ctl cycle %0d got done=%b busy=%b want done=%b busy=1",
                 name, c, done1, busy1, (c == 9));
      end
    end
    for (int c = 10; c <= 13; c++) begin
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
        errors++;
        $display("FAIL %s_idle cycle %0d got done=%b busy=%b want 0 0", name, c, done1, busy1);
      end
    end
    checks++;
    if ({pass1, err1, mask1, first1, fv1} !== {(e_err == 3'd0), e_err, e_mask, e_first, e_fv}) begin
      errors++;
      $display("FAIL %s_result got pass=%b err=%0d mask=%b first=%b fv=%b want pass=%b err=%0d mask=%b first=%b fv=%b",
               name, pass1, err1, mask1, first1, fv1,
               (e_err == 3'd0), e_err, e_mask, e_first, e_fv);
    end
  endtask

  task automatic test_midrun_reset();
    mode1 = 0;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a1, b1} !== 2'b01) begin
      errors++;
      $display("FAIL midrst_pre got %b want 01", {a1, b1});
    end
    rst1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({a1, b1, busy1, done1, pass1, err1, mask1, first1, fv1} !== 18'd0) begin
      errors++;
      $display("FAIL midrst_outputs got %b want all zero",
               {a1, b1, busy1, done1, pass1, err1, mask1, first1, fv1});
    end
    rst1 = 1'b0;
    run_sc1("after_rst", 0, 1'b0);
  endtask

  task automatic test_held_sc3();
    logic [1:0] q[$];
    logic [1:0] exp_ab;
    @(posedge clk); #1 start3 = 1'b1;
    for (int c = 1; c <= 19; c++)
      q.push_back((c == 19) ? 2'd0 : (c > 16) ? 2'd3 : 2'((c - 1) / 4));
    @(posedge clk);
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (c <= 19) begin
        exp_ab = q.pop_front();
        checks++;
        if ({a3, b3} !== exp_ab) begin
          errors++;
          $display("FAIL sc3_vec cycle %0d got %b want %b", c, {a3, b3}, exp_ab);
        end
      end
      if (c == 19) start3 = 1'b0;
      checks++;
      if (done3 !== (c == 17 || c == 35) || busy3 !== (c != 18 && c != 36)) begin
        errors++;
        $display("FAIL sc3_ctl cycle %0d got done=%b busy=%b", c, done3, busy3);
      end
    end
    checks++;
    if ({pass3, err3, mask3, fv3} !== {1'b1, 3'd0, 7'd0, 1'b0}) begin
      errors++;
      $display("FAIL sc3_result got pass=%b err=%0d mask=%b fv=%b want 1 0 0 0",
               pass3, err3, mask3, fv3);
    end
  endtask

  initial begin
    test_reset();
    run_sc1("good", 0, 1'b0);
    run_sc1("xor_stuck", 1, 1'b0);
    run_sc1("all_zero", 2, 1'b0);
    run_sc1("start_poke", 0, 1'b1);
    test_midrun_reset();
    test_held_sc3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
